// File: rtl/tlc_actuated.sv
// Actuated two-phase traffic light controller: rests in NS green until an EW
// vehicle or pedestrian request arrives, with a walk lamp and a flash mode.
module tlc_actuated #(
  parameter int TW          = 4,
  parameter int GREEN_TIME  = 5,
  parameter int YELLOW_TIME = 2,
  parameter int ALLRED_TIME = 1,
  parameter int WALK_TIME   = 3
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       ew_sensor,
  input  logic       ped_req,
  input  logic       flash_en,
  output logic       ns_r,
  output logic       ns_y,
  output logic       ns_g,
  output logic       ew_r,
  output logic       ew_y,
  output logic       ew_g,
  output logic       walk,
  output logic [2:0] state
);

  typedef enum logic [2:0] {
    NS_GRN = 3'd0,
    NS_YEL = 3'd1,
    AR1    = 3'd2,
    EW_GRN = 3'd3,
    EW_YEL = 3'd4,
    AR2    = 3'd5,
    FLASH  = 3'd6,
    BAD    = 3'd7
  } state_e;

  localparam logic [TW-1:0] G_LD    = TW'(GREEN_TIME - 1);
  localparam logic [TW-1:0] Y_LD    = TW'(YELLOW_TIME - 1);
  localparam logic [TW-1:0] AR_LD   = TW'(ALLRED_TIME - 1);
  localparam logic [TW-1:0] WALK_TH = TW'(GREEN_TIME - WALK_TIME);

  state_e        state_q, state_d;
  logic [TW-1:0] timer_q, timer_d;
  logic          ew_pend_q, ew_pend_d;
  logic          ped_pend_q, ped_pend_d;
  logic          walk_act_q, walk_act_d;
  logic          phase_q, phase_d;
  logic          expired, any_req;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= NS_GRN;
      timer_q    <= G_LD;
      ew_pend_q  <= 1'b0;
      ped_pend_q <= 1'b0;
      walk_act_q <= 1'b0;
      phase_q    <= 1'b0;
    end else begin
      state_q    <= state_d;
      timer_q    <= timer_d;
      ew_pend_q  <= ew_pend_d;
      ped_pend_q <= ped_pend_d;
      walk_act_q <= walk_act_d;
      phase_q    <= phase_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    timer_d    = timer_q - 1'b1;
    phase_d    = phase_q;
    walk_act_d = walk_act_q;
    expired    = (timer_q == '0);
    any_req    = ew_pend_q | ped_pend_q | ew_sensor | ped_req;

    if (state_q == BAD) begin
      state_d = AR2;
      timer_d = AR_LD;
    end else if (state_q == FLASH) begin
      if (!flash_en) begin
        state_d = AR2;
        timer_d = AR_LD;
      end else if (expired) begin
        phase_d = ~phase_q;
        timer_d = Y_LD;
      end
    end else if (flash_en) begin
      state_d    = FLASH;
      timer_d    = Y_LD;
      phase_d    = 1'b1;
      walk_act_d = 1'b0;
    end else if (expired) begin
      case (state_q)
        NS_GRN: begin
          // With no demand the green simply restarts (rest-in-NS-green).
          walk_act_d = 1'b0;
          if (any_req) begin
            state_d = NS_YEL;
            timer_d = Y_LD;
          end else begin
            timer_d = G_LD;
          end
        end
        NS_YEL: begin state_d = AR1;    timer_d = AR_LD; end
        AR1:    begin state_d = EW_GRN; timer_d = G_LD;  end
        EW_GRN: begin state_d = EW_YEL; timer_d = Y_LD;  end
        EW_YEL: begin state_d = AR2;    timer_d = AR_LD; end
        AR2: begin
          state_d    = NS_GRN;
          timer_d    = G_LD;
          walk_act_d = ped_pend_q | ped_req;
        end
        default: ;
      endcase
    end

    // Entry into the serving green clears the request it serves.
    ew_pend_d  = (ew_pend_q | ew_sensor) & ~((state_d == EW_GRN) && (state_q != EW_GRN));
    ped_pend_d = (ped_pend_q | ped_req) & ~((state_d == NS_GRN) && (state_q != NS_GRN));
  end

  always_comb begin
    ns_r = 1'b0;
    ns_y = 1'b0;
    ns_g = 1'b0;
    ew_r = 1'b0;
    ew_y = 1'b0;
    ew_g = 1'b0;
    case (state_q)
      NS_GRN: begin ns_g = 1'b1; ew_r = 1'b1; end
      NS_YEL: begin ns_y = 1'b1; ew_r = 1'b1; end
      EW_GRN: begin ew_g = 1'b1; ns_r = 1'b1; end
      EW_YEL: begin ew_y = 1'b1; ns_r = 1'b1; end
      FLASH:  begin ns_y = phase_q; ew_r = phase_q; end
      default: begin ns_r = 1'b1; ew_r = 1'b1; end
    endcase
  end

  assign walk  = walk_act_q & (state_q == NS_GRN) & (timer_q >= WALK_TH);
  assign state = state_q;

endmodule

// File: doc/tlc_actuated.md
TLC_ACTUATED -- requirements
Module: tlc_actuated

Interface
REQ-001 Parameter TW, 4, timer width in bits.
REQ-002 Parameter GREEN_TIME, 5, green interval in cycles, 1..2^TW.
REQ-003 Parameter YELLOW_TIME, 2, yellow interval and flash half-period in cycles, 1..2^TW.
REQ-004 Parameter ALLRED_TIME, 1, all-red clearance interval in cycles, 1..2^TW.
REQ-005 Parameter WALK_TIME, 3, walk interval in cycles, 1..GREEN_TIME.
REQ-006 clk  in  1  single clock; all state changes on its rising edge.
REQ-007 rst  in  1  synchronous, active-high reset.
REQ-008 ew_sensor  in  1  vehicle present on the EW approach; level, sampled every cycle.
REQ-009 ped_req  in  1  pedestrian button for the crossing parallel to NS; one-cycle pulse or level.
REQ-010 flash_en  in  1  fault/night flash mode request; level.
REQ-011 ns_r, ns_y, ns_g  out  1 each  north-south lamps.
REQ-012 ew_r, ew_y, ew_g  out  1 each  east-west lamps.
REQ-013 walk  out  1  pedestrian walk lamp.
REQ-014 state  out  3  current state code, per REQ-016.

Function
REQ-015 The block SHALL hold a TW-bit down-counter "timer"; on entry to a state with duration T it loads T-1; a state expires in the cycle where timer==0, so every state lasts exactly T cycles.
REQ-016 States: NS_GRN=0 (G), NS_YEL=1 (Y), AR1=2 (AR), EW_GRN=3 (G), EW_YEL=4 (Y), AR2=5 (AR), FLASH=6 (Y per phase); code 7 SHALL go to AR2 on the next cycle.
REQ-017 Registered flag ew_pend SHALL be set in any cycle with ew_sensor=1 and cleared on the entry edge to EW_GRN; clear wins over a simultaneous set.
REQ-018 Registered flag ped_pend SHALL be set in any cycle with ped_req=1 and cleared on the entry edge to NS_GRN; ped_req in that same cycle counts as served, not left pending.
REQ-019 NS_GRN on expiry: if ew_pend|ped_pend|ew_sensor|ped_req -> NS_YEL; else it SHALL stay in NS_GRN, reload GREEN_TIME-1 and clear walk_act (rest-in-NS-green).
REQ-020 Unconditional on expiry: NS_YEL->AR1, AR1->EW_GRN, EW_GRN->EW_YEL, EW_YEL->AR2, AR2->NS_GRN.
REQ-021 walk_act SHALL be set on entry to NS_GRN when ped_pend|ped_req, else cleared; it is also cleared on NS_GRN expiry.
REQ-022 walk = walk_act & (state==NS_GRN) & (timer >= GREEN_TIME-WALK_TIME): high for exactly the first WALK_TIME cycles of the serving green.
REQ-023 flash_en=1 in any non-FLASH state SHALL force FLASH on the next edge, overriding expiry, with flash phase=1 and timer=YELLOW_TIME-1; walk_act is cleared.
REQ-024 In FLASH the phase bit SHALL toggle at each timer expiry (timer reloads YELLOW_TIME-1); ns_y=ew_r=phase, all other lamps and walk 0.
REQ-025 In FLASH, flash_en=0 SHALL go to AR2 (timer ALLRED_TIME-1) on the next edge, then NS_GRN per REQ-020; pending flags keep accumulating during FLASH.
REQ-026 Lamps are a decode of state: NS_GRN ns_g+ew_r; NS_YEL ns_y+ew_r; EW_GRN ew_g+ns_r; EW_YEL ew_y+ns_r; AR1/AR2 ns_r+ew_r.
REQ-027 Never both approaches non-red outside FLASH; at most one lamp per approach lit in every cycle.

Reset
REQ-028 With rst=1 at an edge: state=NS_GRN, timer=GREEN_TIME-1, ew_pend=ped_pend=walk_act=0, phase=0; rst overrides flash_en and all requests.
REQ-029 Outputs after reset: ns_g=1, ew_r=1, all other lamps 0, walk=0, state=0.

Verification (defaults G=5, Y=2, AR=1, W=3)
REQ-030 Reset, inputs 0 for 30 cycles -> state stays 0, ns_g=ew_r=1 throughout, walk=0.
REQ-031 1-cycle ew_sensor pulse in cycle 2 of NS_GRN -> NS_GRN ends on its cycle 5, then states 1,1,2,3x5,4x2,5,0; EW_GRN is not re-entered afterwards.
REQ-032 1-cycle ped_req pulse during NS_GRN -> full cycle to AR2, then walk=1 for exactly the first 3 of the next 5 NS_GRN cycles; ped_pend=0 afterwards.
REQ-033 flash_en raised in cycle 2 of EW_GRN -> state=6 next cycle; ns_y and ew_r toggle together every 2 cycles, all greens 0; drop flash_en -> 1 cycle state 5, then state 0.
REQ-034 rst pulse in cycle 1 of EW_YEL with ew_pend=1 -> next cycle state 0, ns_g=1, ew_pend=0, and with ew_sensor=0 it rests in NS_GRN.
REQ-035 Random ew_sensor/ped_req/flash_en for 10k cycles -> REQ-027 lamp-safety checks hold every cycle.
